pdm_audio_stream: RTL and testbench
===================================

Name: pdm_audio_stream

Overview:
- Parametrised PDM microphone front end, successor to the inline mic/decimation logic in the top level.
- Generates the mic clock and decimates the 1-bit PDM stream into signed PCM samples.
- Frames the samples into FRAME_LEN blocks with a last flag, in continuous or record-gated mode.
- Buffers samples in a FIFO behind a valid/ready stream port that feeds the FFT input directly.

Parameters:
- CLK_DIV, 32: clk_in cycles per mic_clk period. Even, >=4.
- DECIM_LOG2, 8: decimation ratio is 2^DECIM_LOG2 PDM bits per sample.
- SAMPLE_W, 16: output sample width. Must be >= DECIM_LOG2.
- FRAME_LEN, 1024: samples per frame. >=2.
- FIFO_DEPTH, 16: output FIFO entries. Power of 2, >=2.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- mic_data  in  1  PDM bit from microphone
- mic_clk  out  1  microphone clock
- mode_in  in  1  0 = continuous, 1 = gated by record_in
- record_in  in  1  debounced record level
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream ready
- m_data  out  SAMPLE_W  signed sample
- m_last  out  1  last sample of frame
- sample_tap_valid  out  1  1-cycle pulse per decimated sample (pre-FIFO, debug)
- overflow  out  1  sticky: a sample was dropped on a full FIFO
- frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset: mic_clk=0, m_valid=0, m_data=0, m_last=0, sample_tap_valid=0, overflow=0, frame_count=0. Divider, tally, frame counter and FIFO pointers cleared. State = IDLE. Reset mid-frame discards the partial frame and all FIFO contents.
- Mic clock: counter runs 0..CLK_DIV-1. mic_clk is registered as (cnt < CLK_DIV/2).
- pdm_step = mic_clk & ~mic_clk_d. On pdm_step, mic_data is sampled.
- Decimation: tally counts exactly 2^DECIM_LOG2 steps. Fixes the old N+1 off-by-one.
- On the final step, the 1-cycle-later sample is computed as s = tally_incl_final - 2^(DECIM_LOG2-1). Tally width is DECIM_LOG2+1.
- s is saturated to [-2^(D-1), 2^(D-1)-1], then left-shifted by SAMPLE_W-DECIM_LOG2.
- sample_tap_valid pulses when the sample is produced. Tally restarts at 0 for the next step.
- Sample period = CLK_DIV*2^DECIM_LOG2 cycles.
- Frame FSM states:
  - IDLE: continuous mode goes to CAPTURE at the next produced sample. Gated mode goes to CAPTURE at the first produced sample with record_in=1. Samples in IDLE are not written.
  - CAPTURE: each accepted sample is written with last = (fidx==FRAME_LEN-1). fidx advances only on accepted writes.
  - At the last write: fidx returns to 0 and frame_count increments. Continuous mode, or gated mode with record_in=1, stays in CAPTURE; otherwise the FSM goes to IDLE.
  - record_in falling mid-frame does not truncate; the frame completes.
  - mode_in is sampled only in IDLE and at frame boundaries.
- FIFO:
  - Write latency 1 cycle from sample_tap_valid.
  - m_valid asserts the cycle after the write into an empty FIFO.
  - m_data/m_last stay stable while m_valid & ~m_ready.
  - Pop on m_valid & m_ready.
  - Full with a simultaneous pop: the write is accepted.
  - Full without a pop: the sample is dropped, overflow sets sticky until reset, and fidx does not advance.
- No combinational path from m_ready to m_valid.

Decomposition:
- Package pdm_stream_pkg holds:
  - mode localparams MODE_CONT=1'b0 and MODE_GATED=1'b1
  - state enum {IDLE, CAPTURE}
  - packed struct fifo_entry_t {last, data}, with the width parameterised via a SAMPLE_W localparam default
- One sub-module, stream_fifo: synchronous FIFO with first-word-fall-through output, parameterised width and depth, and full/empty flags.

Test Plan:
1. D=8, W=16, mic_data=1 constant, m_ready=1 -> every sample = 0x7F00 (256-128 saturated to 127, shifted 8); sample_tap_valid period 8192 cycles.
2. mic_data=0 -> 0x8000. Alternating 1/0 per pdm_step -> 0x0000. Check mic_clk high for 16 of every 32 cycles.
3. FRAME_LEN=4, continuous, m_ready=1 -> m_last on every 4th output; frame_count=3 after 12 samples.
4. Gated mode, FRAME_LEN=4: record_in high for 1 sample then low -> exactly 4 samples with last on the 4th, then IDLE, no further writes; frame_count=1.
5. FIFO_DEPTH=4, m_ready=0 for 6 samples -> 4 stored, overflow=1. Then m_ready=1 -> 4 pops in order with data stable while stalled; the frame index excludes the 2 dropped samples.
6. Assert rst_in mid-frame with 3 FIFO entries -> next cycle all outputs at reset values and m_valid=0; a fresh frame starts at fidx 0.

Source files
------------

// File: rtl/pdm_audio_stream_pkg.sv
// ============================================================================
// Module      : pdm_stream_pkg
// Description : Shared definitions for the PDM audio front end. These are the
//               capture-mode encodings, the frame FSM state type and the
//               FIFO entry layout.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_stream_pkg;

    // Capture mode selected by mode_in.
    localparam logic MODE_CONT  = 1'b0;   // frames back to back
    localparam logic MODE_GATED = 1'b1;   // frames start only while record_in is high

    // Default sample width used by the packed FIFO entry layout.
    localparam int SAMPLE_W_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // One FIFO word. The last flag sits above the sample bits.
    typedef struct packed {
        logic                        last;
        logic [SAMPLE_W_DEFAULT-1:0] data;
    } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/pdm_audio_stream_fifo.sv
// ============================================================================
// Module      : stream_fifo
// Description : Synchronous FIFO with first-word-fall-through read data.
//               A write into a full FIFO is accepted only when a read happens
//               in the same cycle.
// Ports       : clk_i/rst_i     clock, synchronous active-high reset
//               wr_en_i/wr_data_i  write request and data
//               rd_en_i          pop the head entry (ignored when empty)
//               rd_data_o        head entry, valid whenever empty_o is low
//               full_o/empty_o   occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    logic w_full;
    logic w_empty;
    logic w_do_rd;
    logic w_do_wr;

    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    assign w_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign w_empty = (wptr_q == rptr_q);
    assign w_do_rd = rd_en_i & ~w_empty;
    assign w_do_wr = wr_en_i & (~w_full | w_do_rd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // The storage is not reset. Its contents are only visible through rd_data_o when the FIFO is not empty.
    always_ff @(posedge clk_i) begin
        if (w_do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rptr_q[AW-1:0]];
    assign full_o    = w_full;
    assign empty_o   = w_empty;

endmodule

`default_nettype wire

// File: rtl/pdm_audio_stream.sv
// ============================================================================
// Module      : pdm_audio_stream
// Description : PDM microphone front end. It generates mic_clk, decimates the
//               1-bit stream into signed PCM samples and frames them into
//               FRAME_LEN blocks. The samples are delivered through a FIFO on
//               a valid/ready stream port.
// Ports       : clk_in/rst_in        system clock, sync active-high reset
//               mic_data/mic_clk     PDM bit in, microphone clock out
//               mode_in/record_in    continuous or record-gated capture
//               m_valid/m_ready/m_data/m_last  sample stream
//               sample_tap_valid     pulse per decimated sample (pre-FIFO)
//               overflow             sticky sample-dropped flag
//               frame_count          completed frames, wraps at 2^16
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_audio_stream
    import pdm_stream_pkg::*;
#(
    parameter int CLK_DIV    = 32,
    parameter int DECIM_LOG2 = 8,
    parameter int SAMPLE_W   = 16,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                mic_data,
    output logic                mic_clk,
    input  logic                mode_in,
    input  logic                record_in,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] m_data,
    output logic                m_last,
    output logic                sample_tap_valid,
    output logic                overflow,
    output logic [15:0]         frame_count
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int FIDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam int SHIFT  = SAMPLE_W - DECIM_LOG2;

    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_HALF  = CNT_W'(CLK_DIV / 2);
    localparam logic [DECIM_LOG2-1:0] STEP_MAX  = '1;
    localparam logic [DECIM_LOG2-1:0] MID       = DECIM_LOG2'(2 ** (DECIM_LOG2 - 1));
    localparam logic [DECIM_LOG2-1:0] POS_MAX   = MID - 1'b1;
    localparam logic [FIDX_W-1:0]     FIDX_LAST = FIDX_W'(FRAME_LEN - 1);

    // ------------------------------------------------------------------
    // Microphone clock
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic             mic_clk_q;
    logic             mic_clk_prev_q;
    logic             w_pdm_step;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q          <= '0;
            mic_clk_q      <= 1'b0;
            mic_clk_prev_q <= 1'b0;
        end else begin
            cnt_q          <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            mic_clk_q      <= (cnt_q < CNT_HALF);
            mic_clk_prev_q <= mic_clk_q;
        end
    end

    // mic_data is taken in the cycle right after each mic_clk rise.
    assign w_pdm_step = mic_clk_q & ~mic_clk_prev_q;
    assign mic_clk    = mic_clk_q;

    // ------------------------------------------------------------------
    // Decimation: count the ones over exactly 2^DECIM_LOG2 steps
    // ------------------------------------------------------------------
    logic [DECIM_LOG2-1:0]      step_cnt_q;
    logic [DECIM_LOG2:0]        tally_q;
    logic                       final_q;
    logic                       tap_q;
    logic [SAMPLE_W-1:0]        sample_q;
    logic signed [DECIM_LOG2-1:0] w_sat;
    logic [SAMPLE_W-1:0]        w_sample;

    // The tally can only reach 2^D when every bit was one. That case saturates to the largest positive code.
    // Every other tally, minus the midpoint, already fits in D bits.
    assign w_sat    = tally_q[DECIM_LOG2] ? POS_MAX : (tally_q[DECIM_LOG2-1:0] - MID);
    assign w_sample = SAMPLE_W'(w_sat) << SHIFT;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            step_cnt_q <= '0;
            tally_q    <= '0;
            final_q    <= 1'b0;
            tap_q      <= 1'b0;
            sample_q   <= '0;
        end else begin
            final_q <= w_pdm_step && (step_cnt_q == STEP_MAX);
            tap_q   <= final_q;
            if (w_pdm_step) begin
                step_cnt_q <= step_cnt_q + 1'b1;
                tally_q    <= tally_q + {{DECIM_LOG2{1'b0}}, mic_data};
            end else if (final_q) begin
                // The tally now includes the final bit. Convert it and restart the count.
                sample_q <= w_sample;
                tally_q  <= '0;
            end
        end
    end

    assign sample_tap_valid = tap_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [FIDX_W-1:0]  fidx_q;
    logic [FIDX_W-1:0]  fidx_d;
    logic [15:0]        frame_cnt_q;
    logic [15:0]        frame_cnt_d;
    logic               overflow_q;
    logic               overflow_d;

    logic               w_wr_try;
    logic               w_wr_last;
    logic               w_wr_ok;
    logic               w_continue;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_fifo_valid;
    logic               w_pop;
    logic [SAMPLE_W:0]  w_rd_data;

    assign w_fifo_valid = ~w_fifo_empty;
    assign w_pop        = w_fifo_valid & m_ready;
    assign w_continue   = (mode_in == MODE_CONT) || ((mode_in == MODE_GATED) && record_in);
    // A full FIFO still accepts the write when it is popped in the same cycle.
    assign w_wr_ok      = w_wr_try & (~w_fifo_full | w_pop);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            fidx_q      <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fidx_q      <= fidx_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fidx_d      = fidx_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                // The sample that starts capture is not written.
                if (tap_q && w_continue) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_wr_try && !w_wr_ok) begin
                    overflow_d = 1'b1;
                end
                if (w_wr_ok) begin
                    if (w_wr_last) begin
                        fidx_d      = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (!w_continue) begin
                            state_d = IDLE;
                        end
                    end else begin
                        fidx_d = fidx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_wr_try  = 1'b0;
        w_wr_last = 1'b0;
        if ((state_q == CAPTURE) && tap_q) begin
            w_wr_try  = 1'b1;
            w_wr_last = (fidx_q == FIDX_LAST);
        end
    end

    assign overflow    = overflow_q;
    assign frame_count = frame_cnt_q;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    stream_fifo #(
        .WIDTH (SAMPLE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .wr_en_i   (w_wr_ok),
        .wr_data_i ({w_wr_last, sample_q}),
        .rd_en_i   (w_pop),
        .rd_data_o (w_rd_data),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

    // Data is zero while nothing is presented. This keeps the reset values defined even though the storage is not reset.
    assign m_valid = w_fifo_valid;
    assign m_data  = w_fifo_valid ? w_rd_data[SAMPLE_W-1:0] : '0;
    assign m_last  = w_fifo_valid & w_rd_data[SAMPLE_W];

endmodule

`default_nettype wire

// File: tb/tb_pdm_audio_stream.sv
// ============================================================================
// Module      : tb_pdm_audio_stream
// Description : Scoreboard bench for pdm_audio_stream. A sample-level model
//               predicts each decimated sample and whether it is framed,
//               dropped or ignored. A monitor compares the stream port with
//               the queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_audio_stream;

    localparam int CLK_DIV    = 4;
    localparam int DECIM_LOG2 = 4;
    localparam int SAMPLE_W   = 8;
    localparam int FRAME_LEN  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int NBITS      = 1 << DECIM_LOG2;
    localparam int PERIOD     = CLK_DIV * NBITS;

    logic                clk_in    = 1'b0;
    logic                rst_in    = 1'b1;
    logic                mic_data  = 1'b1;
    logic                mode_in   = 1'b0;
    logic                record_in = 1'b0;
    logic                m_ready   = 1'b0;
    logic                mic_clk;
    logic                m_valid;
    logic [SAMPLE_W-1:0] m_data;
    logic                m_last;
    logic                sample_tap_valid;
    logic                overflow;
    logic [15:0]         frame_count;

    pdm_audio_stream #(
        .CLK_DIV    (CLK_DIV),
        .DECIM_LOG2 (DECIM_LOG2),
        .SAMPLE_W   (SAMPLE_W),
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .mic_data         (mic_data),
        .mic_clk          (mic_clk),
        .mode_in          (mode_in),
        .record_in        (record_in),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .sample_tap_valid (sample_tap_valid),
        .overflow         (overflow),
        .frame_count      (frame_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [SAMPLE_W-1:0] data;
        logic                last;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int bitcnt   = 0;
    int ones     = 0;
    int produced = 0;
    int fidx     = 0;
    int frames   = 0;
    bit cap      = 1'b0;
    bit exp_ovf  = 1'b0;
    int pat      = 0;     // 0 ones, 1 zeros, 2 alternating, 3 random density
    int density  = 50;
    bit alt_ph   = 1'b0;
    int rdy_mode = 1;     // 0 hold low, 1 hold high, 2 random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SAMPLE_W-1:0] expect_sample(input int n);
        int s;
        s = n - NBITS / 2;
        if (s > NBITS / 2 - 1) s = NBITS / 2 - 1;
        if (s < -(NBITS / 2)) s = -(NBITS / 2);
        return SAMPLE_W'(s * (1 << (SAMPLE_W - DECIM_LOG2)));
    endfunction

    function automatic logic next_bit();
        case (pat)
            0: return 1'b1;
            1: return 1'b0;
            2: begin alt_ph = ~alt_ph; return alt_ph; end
            default: return ($urandom_range(99) < density) ? 1'b1 : 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        sb.delete();
        bitcnt  = 0;
        ones    = 0;
        fidx    = 0;
        frames  = 0;
        cap     = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_sample(input int n);
        exp_t e;
        bit   go;
        go = (mode_in == 1'b0) || record_in;
        produced++;
        if (!cap) begin
            if (go) cap = 1'b1;
        end else if (sb.size() >= FIFO_DEPTH) begin
            exp_ovf = 1'b1;
        end else begin
            e.data = expect_sample(n);
            e.last = (fidx == FRAME_LEN - 1);
            sb.push_back(e);
            if (fidx == FRAME_LEN - 1) begin
                fidx   = 0;
                frames = frames + 1;
                cap    = go;
            end else begin
                fidx++;
            end
        end
    endtask

    // Model: collect one bit per mic_clk rise and form a sample every NBITS bits.
    initial begin
        forever begin
            @(posedge mic_clk);
            if (!rst_in) begin
                ones = ones + int'(mic_data);
                bitcnt++;
                if (bitcnt == NBITS) begin
                    model_sample(ones);
                    bitcnt = 0;
                    ones   = 0;
                end
            end
        end
    end

    // Microphone: new bit after each fall, stable across the next rise
    initial begin
        forever begin
            @(negedge mic_clk);
            #1;
            mic_data = next_bit();
        end
    end

    // Downstream ready
    initial begin
        forever begin
            @(posedge clk_in);
            #2;
            m_ready = (rdy_mode == 1) || ((rdy_mode == 2) && ($urandom_range(1) == 1));
        end
    end

    // Monitor: compare on every handshake, and check stability while stalled
    initial begin
        logic [SAMPLE_W-1:0] hold_data;
        logic                hold_last;
        bit                  holding;
        holding = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                holding = 1'b0;
            end else begin
                if (m_valid && holding) begin
                    check("stall_data", m_data, hold_data);
                    check("stall_last", m_last, hold_last);
                end
                holding = 1'b0;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %0h expected none", m_data);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("data", m_data, e.data);
                        check("last", m_last, e.last);
                    end
                end else if (m_valid) begin
                    holding   = 1'b1;
                    hold_data = m_data;
                    hold_last = m_last;
                end
            end
        end
    end

    // Tap spacing: one pulse every CLK_DIV * 2^DECIM_LOG2 cycles
    initial begin
        int cyc;
        int last_cyc;
        int nchk;
        cyc      = 0;
        last_cyc = -1;
        nchk     = 0;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (rst_in) begin
                last_cyc = -1;
            end else if (sample_tap_valid) begin
                if (last_cyc >= 0 && nchk < 8) begin
                    check("tap_period", cyc - last_cyc, PERIOD);
                    nchk++;
                end
                last_cyc = cyc;
            end
        end
    end

    task automatic wait_samples(input int n);
        int target;
        int guard;
        target = produced + n;
        guard  = 0;
        while (produced < target && guard < (n + 4) * PERIOD) begin
            @(posedge clk_in);
            #2;
            guard++;
        end
        if (produced < target) begin
            total++;
            bad++;
            $display("FAIL sample_timeout: got %0d samples expected %0d", produced, target);
        end
    endtask

    task automatic to_mid();
        int guard;
        guard = 0;
        do begin
            @(posedge clk_in);
            #2;
            guard++;
        end while (bitcnt != NBITS / 2 && guard < 4 * PERIOD);
        if (bitcnt != NBITS / 2) begin
            total++;
            bad++;
            $display("FAIL mid_timeout: got bitcnt %0d expected %0d", bitcnt, NBITS / 2);
        end
    endtask

    task automatic check_reset_values();
        check("rst_mic_clk", mic_clk, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_tap", sample_tap_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_count", frame_count, 0);
    endtask

    initial begin
        int hi;
        int f0;

        rst_in   = 1'b1;
        rdy_mode = 1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_values();
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        model_reset();

        // mic_clk duty cycle over whole periods
        hi = 0;
        repeat (8 * CLK_DIV) begin
            @(negedge clk_in);
            if (mic_clk) hi++;
        end
        check("mic_clk_high_cycles", hi, 4 * CLK_DIV);

        // All ones, continuous mode: first sample starts capture, 12 written -> 3 frames
        wait_samples(13);
        to_mid();
        check("frame_count_cont", frame_count, 3);
        check("overflow_clear", overflow, 0);

        // All zeros, alternating, then random densities with random ready
        pat      = 1;
        rdy_mode = 2;
        wait_samples(5);
        to_mid();
        pat = 2;
        wait_samples(5);
        to_mid();
        pat = 3;
        for (int i = 0; i < 12; i++) begin
            density = $urandom_range(100);
            wait_samples(1);
            to_mid();
        end
        check("frame_count_model", frame_count, frames);

        // Gated mode: drop back to IDLE, then record for one sample period
        mode_in   = 1'b1;
        record_in = 1'b0;
        wait_samples(6);
        to_mid();
        f0 = frames;
        check("frame_count_pre_gate", frame_count, f0);
        record_in = 1'b1;
        wait_samples(1);
        to_mid();
        record_in = 1'b0;
        wait_samples(8);
        to_mid();
        check("frame_count_gated", frame_count, (f0 + 1) & 16'hFFFF);
        check("gated_pending", sb.size(), 0);

        // Overflow: ready low across 6 framed samples -> 4 stored, 2 dropped
        rdy_mode = 0;
        mode_in  = 1'b0;
        wait_samples(7);
        to_mid();
        check("overflow_set", overflow, 1);
        check("full_valid", m_valid, 1);
        rdy_mode = 1;
        wait_samples(4);
        to_mid();
        check("overflow_sticky", overflow, 1);
        check("frame_count_ovf", frame_count, frames);

        // Reset mid-frame with 3 entries queued
        mode_in = 1'b1;
        wait_samples(6);
        to_mid();
        rdy_mode = 0;
        mode_in  = 1'b0;
        wait_samples(4);
        to_mid();
        check("pre_reset_valid", m_valid, 1);
        rst_in = 1'b1;
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        check_reset_values();
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        model_reset();
        rdy_mode = 2;
        pat      = 3;
        density  = 70;
        wait_samples(10);
        to_mid();
        check("frame_count_after_reset", frame_count, 2);
        rdy_mode = 1;
        wait_samples(1);
        to_mid();
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
